// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter, LSB first, BPS_T clock cycles per bit.
// Define TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx_module #(
    parameter logic [12:0] BPS_T = 13'd5208
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    output logic       TX_Pin_Out,
    output logic       Busy_Sig,
    output logic       TX_Done_Sig
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    localparam logic [12:0] BPS_LAST = BPS_T - 13'd1;

    state_t      state_r, state_s;
    logic [12:0] cnt_r, cnt_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        pin_r, pin_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
`ifdef TX_PARITY_EN
    logic        parity_r, parity_s;
`endif

    logic        wrap_s;
    logic [12:0] cnt_nxt_s;

    assign wrap_s    = (cnt_r == BPS_LAST);
    assign cnt_nxt_s = wrap_s ? 13'd0 : (cnt_r + 13'd1);

    // Next-state, bit timing and next line value for the transmit FSM
    always_comb begin
        state_s   = state_r;
        cnt_s     = 13'd0;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        pin_s     = pin_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
`ifdef TX_PARITY_EN
        parity_s  = parity_r;
`endif
        case (state_r)
            IDLE: begin
                pin_s     = 1'b1;
                busy_s    = 1'b0;
                bit_idx_s = 3'd0;
                if (TX_En_Sig) begin
                    state_s  = START;
                    shift_s  = TX_Data;
                    pin_s    = 1'b0;
                    busy_s   = 1'b1;
`ifdef TX_PARITY_EN
                    parity_s = ^TX_Data;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                cnt_s = cnt_nxt_s;
                if (wrap_s) begin
                    state_s = DATA;
                    pin_s   = shift_r[0];
                end else begin
                    pin_s = 1'b0;
                end
            end
            DATA: begin
                cnt_s = cnt_nxt_s;
                // shift_r[0] is always the bit currently on the line
                if (wrap_s) begin
                    if (bit_idx_r == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_s = PARITY;
                        pin_s   = parity_r;
`else
                        state_s = STOP;
                        pin_s   = 1'b1;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        pin_s     = shift_r[1];
                    end
                end else begin
                    pin_s = shift_r[0];
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                cnt_s = cnt_nxt_s;
                if (wrap_s) begin
                    state_s = STOP;
                    pin_s   = 1'b1;
                end else begin
                    pin_s = parity_r;
                end
            end
`endif
            STOP: begin
                cnt_s = cnt_nxt_s;
                pin_s = 1'b1;
                if (wrap_s) begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s   = IDLE;
                bit_idx_s = 3'd0;
                pin_s     = 1'b1;
                busy_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= IDLE;
            cnt_r     <= 13'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            pin_r     <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            pin_r     <= pin_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
`ifdef TX_PARITY_EN
            parity_r  <= parity_s;
`endif
        end
    end

    assign TX_Pin_Out  = pin_r;
    assign Busy_Sig    = busy_r;
    assign TX_Done_Sig = done_r;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module: instance A at 16 cycles/bit, instance B at the minimum of 2.
module tb_uart_tx_module;

    localparam int BPS_A = 16;
    localparam int BPS_B = 2;
`ifdef TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       en_a, en_b;
    logic [7:0] tx_data;
    logic       pin_a, busy_a, done_a;
    logic       pin_b, busy_b, done_b;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    uart_tx_module #(.BPS_T(13'd16)) dut_a (
        .CLK(CLK), .RST(RST), .TX_En_Sig(en_a), .TX_Data(tx_data),
        .TX_Pin_Out(pin_a), .Busy_Sig(busy_a), .TX_Done_Sig(done_a)
    );

    uart_tx_module #(.BPS_T(13'd2)) dut_b (
        .CLK(CLK), .RST(RST), .TX_En_Sig(en_b), .TX_Data(tx_data),
        .TX_Pin_Out(pin_b), .Busy_Sig(busy_b), .TX_Done_Sig(done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic pin_of(input bit sel);
        return sel ? pin_b : pin_a;
    endfunction

    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction

    task automatic set_en(input bit sel, input logic v);
        if (sel) en_b = v;
        else     en_a = v;
    endtask

    // Issue a request; returns #1 after the accepting edge, inside the first START cycle.
    task automatic start_req(input bit sel, input logic [7:0] b);
        @(negedge CLK);
        set_en(sel, 1'b1);
        tx_data = b;
        @(posedge CLK);
        #1;
        set_en(sel, 1'b0);
        tx_data = ~b;
    endtask

    // Check every cycle of one frame, then the TX_Done_Sig cycle; optionally chain the next request.
    task automatic frame_check(input bit sel, input logic [7:0] b, input bit disturb,
                               input bit chain, input logic [7:0] nb, input string tag);
        logic [10:0] exp_bits;
        logic ok_pin, ok_busy, ok_done;
        int bps;
        bps = sel ? BPS_B : BPS_A;
        exp_bits = 11'h7FF;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        ok_busy = 1'b1;
        ok_done = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
            ok_pin = 1'b1;
            for (int c = 0; c < bps; c++) begin
                @(negedge CLK);
                if (pin_of(sel) !== exp_bits[k]) ok_pin = 1'b0;
                if (busy_of(sel) !== 1'b1) ok_busy = 1'b0;
                if (done_of(sel) !== 1'b0) ok_done = 1'b0;
                if (disturb && k == 3 && c == 1) begin
                    set_en(sel, 1'b1);
                    tx_data = 8'hFF;
                end else begin
                    set_en(sel, 1'b0);
                end
            end
            chk($sformatf("%s bit%0d", tag, k), ok_pin, 1'b1);
        end
        chk($sformatf("%s busy_in_frame", tag), ok_busy, 1'b1);
        chk($sformatf("%s no_early_done", tag), ok_done, 1'b1);
        @(negedge CLK);
        chk($sformatf("%s done_pulse", tag), done_of(sel), 1'b1);
        chk($sformatf("%s busy_at_done", tag), busy_of(sel), 1'b0);
        chk($sformatf("%s pin_at_done", tag), pin_of(sel), 1'b1);
        if (chain) begin
            set_en(sel, 1'b1);
            tx_data = nb;
            @(posedge CLK);
            #1;
            set_en(sel, 1'b0);
            tx_data = ~nb;
        end else begin
            @(negedge CLK);
            chk($sformatf("%s done_one_cycle", tag), done_of(sel), 1'b0);
            chk($sformatf("%s idle_pin", tag), pin_of(sel), 1'b1);
        end
    endtask

    initial begin
        logic ok;
        RST = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        tx_data = 8'h00;
        #12;
        chk("reset pin_a", pin_a, 1'b1);
        chk("reset busy_a", busy_a, 1'b0);
        chk("reset done_a", done_a, 1'b0);
        chk("reset pin_b", pin_b, 1'b1);
        chk("reset busy_b", busy_b, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("idle pin_a", pin_a, 1'b1);

        // 0x55 alternating pattern
        start_req(1'b0, 8'h55);
        frame_check(1'b0, 8'h55, 1'b0, 1'b0, 8'h00, "f55");

        // Back-to-back: second request in the done cycle
        start_req(1'b0, 8'hA3);
        frame_check(1'b0, 8'hA3, 1'b0, 1'b1, 8'h3C, "fA3");
        frame_check(1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, "f3C");

        // Mid-frame request and data change must be ignored
        start_req(1'b0, 8'h00);
        frame_check(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, "f00");
        ok = 1'b1;
        repeat (4 * BPS_A) begin
            @(negedge CLK);
            if (busy_a !== 1'b0 || pin_a !== 1'b1 || done_a !== 1'b0) ok = 1'b0;
        end
        chk("no_second_frame", ok, 1'b1);

        // Parity-sensitive bytes (odd and even weight)
        start_req(1'b0, 8'h07);
        frame_check(1'b0, 8'h07, 1'b0, 1'b0, 8'h00, "f07");
        start_req(1'b0, 8'h03);
        frame_check(1'b0, 8'h03, 1'b0, 1'b0, 8'h00, "f03");

        // Asynchronous reset during data bit 4
        start_req(1'b0, 8'hC6);
        repeat (5 * BPS_A + BPS_A / 2) @(negedge CLK);
        chk("rst mid_frame_pin", pin_a, 1'b0);
        chk("rst mid_frame_busy", busy_a, 1'b1);
        #1;
        RST = 1'b1;
        en_a = 1'b1;
        tx_data = 8'h00;
        #1;
        chk("rst async_pin", pin_a, 1'b1);
        chk("rst async_busy", busy_a, 1'b0);
        chk("rst async_done", done_a, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        en_a = 1'b0;
        ok = 1'b1;
        repeat (2 * BPS_A) begin
            @(negedge CLK);
            if (busy_a !== 1'b0 || pin_a !== 1'b1 || done_a !== 1'b0) ok = 1'b0;
        end
        chk("rst no_frame_no_done", ok, 1'b1);
        start_req(1'b0, 8'h81);
        frame_check(1'b0, 8'h81, 1'b0, 1'b0, 8'h00, "f81");

        // Minimum bit period
        start_req(1'b1, 8'h5A);
        frame_check(1'b1, 8'h5A, 1'b0, 1'b1, 8'hC3, "b5A");
        frame_check(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, "bC3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
UART_TX_MODULE -- requirements
Module: uart_tx_module

Interface
REQ-001 Parameter BPS_T, default 13'd5208, clock cycles per bit (50 MHz / 9600 baud); legal range 2..8191.
REQ-002 CLK  input  1  system clock; all logic on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 TX_En_Sig  input  1  start request; sampled every CLK.
REQ-005 TX_Data  input  8  byte to send; sampled only in the cycle a request is accepted.
REQ-006 TX_Pin_Out  output  1  serial line; idle high.
REQ-007 Busy_Sig  output  1  high while a frame is on the line.
REQ-008 TX_Done_Sig  output  1  one-cycle pulse at frame completion.

Function
REQ-009 States SHALL be IDLE, START, DATA, PARITY (present only with TX_PARITY_EN), STOP.
REQ-010 A request SHALL be accepted only when TX_En_Sig=1 in IDLE; in any other state TX_En_Sig SHALL be ignored and neither queued nor counted.
REQ-011 On acceptance in cycle N: TX_Data latched into a shift register; state goes to START in N+1; TX_Pin_Out=0 and Busy_Sig=1 from N+1.
REQ-012 Each bit SHALL hold TX_Pin_Out for exactly BPS_T cycles, timed by a 13-bit counter that runs 0..BPS_T-1, wraps to 0, and is held at 0 in IDLE.
REQ-013 A counter wrap SHALL advance state: START->DATA; DATA->DATA until 8 bits are sent, then ->PARITY (if enabled) or ->STOP; PARITY->STOP; STOP->IDLE.
REQ-014 Data bits SHALL be sent LSB first; a 3-bit index tracks the bits sent; latched byte SHALL be unaffected by TX_Data changes mid-frame.
REQ-015 STOP SHALL drive TX_Pin_Out=1 for a full BPS_T cycles.
REQ-016 TX_Done_Sig SHALL be 1 for exactly the first IDLE cycle after STOP; Busy_Sig SHALL be 0 in that cycle.
REQ-017 A request in the TX_Done_Sig cycle SHALL be accepted (back-to-back); the line stays high only in that cycle, preserving a full stop bit.
REQ-018 Frame length from first START cycle to last STOP cycle SHALL be 10*BPS_T cycles (11*BPS_T with parity).
REQ-019 TX_Pin_Out SHALL come straight from a register (glitch-free).

Reset
REQ-020 RST=1 SHALL immediately and asynchronously force: state IDLE, counter 0, bit index 0, shift register 0, TX_Pin_Out=1, Busy_Sig=0, TX_Done_Sig=0.
REQ-021 Reset mid-frame SHALL abort the frame with no TX_Done_Sig; the first request after RST falls SHALL start a complete new frame.
REQ-022 A TX_En_Sig present while RST=1 SHALL be ignored.

Configuration
REQ-023 Macro TX_PARITY_EN: when defined, an even-parity bit (XOR of the 8 latched data bits) SHALL be sent in state PARITY between the last data bit and STOP, for BPS_T cycles.
REQ-024 When TX_PARITY_EN is undefined, the PARITY state and logic SHALL be absent and DATA SHALL go directly to STOP.

Verification
REQ-025 BPS_T=5208, no parity, send 0x55 -> line 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit 5208 cycles; TX_Done_Sig pulses 52080 cycles after the first START cycle.
REQ-026 TX_PARITY_EN, send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; done at 57288 cycles.
REQ-027 Request at Done cycle with 0xA3 then 0x3C -> stop bit exactly 5208 cycles high plus 1 idle cycle, second frame correct, no bit lost.
REQ-028 TX_En_Sig pulsed and TX_Data changed to 0xFF during 0x00 frame -> frame stays 0x00, no second frame, one TX_Done_Sig.
REQ-029 RST asserted during data bit 4 -> TX_Pin_Out=1 and Busy_Sig=0 with no CLK edge needed, no TX_Done_Sig; next request for 0x81 sends a full correct frame.
REQ-030 BPS_T=2 -> each bit 2 cycles, 20-cycle frame, counter wrap correct at minimum value.
